// File: rtl/sub_pipe_pkg.sv
// rtl/sub_pipe_pkg.sv - shared constants, result type and overflow helper for the pipelined subtractor
package sub_pipe_pkg;

    localparam int SUB_WIDTH_DEFAULT = 32;

    // Result record at the default width: unsigned borrow, modular difference, signed overflow.
    typedef struct packed {
        logic                         borrow;
        logic [SUB_WIDTH_DEFAULT-1:0] diff;
        logic                         ovf;
    } sub_result_t;

    // Signed overflow of a - b: only possible when the operand signs differ,
    // and it shows up as a result whose sign disagrees with the minuend.
    function automatic logic ovf_sub(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational N-bit subtract slice with borrow chain
module sub_slice #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N:0] wide;

    // Extend by one bit so the top bit of the result is the borrow out of the slice.
    always_comb begin
        wide       = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, borrow_in};
        diff       = wide[N-1:0];
        borrow_out = wide[N];
    end

endmodule

// File: rtl/sub_pipe_2stage.sv
// rtl/sub_pipe_2stage.sv - two-stage pipelined subtractor with valid/ready on both sides
import sub_pipe_pkg::*;

module sub_pipe_2stage #(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_diff,
    output logic             out_ovf
);

    localparam int HALF = WIDTH / 2;

    // Stage 1: low half already subtracted, high operands carried forward.
    logic            s1_valid;
    logic [HALF-1:0] s1_d_lo;
    logic            s1_bw_lo;
    logic [HALF-1:0] s1_a_hi;
    logic [HALF-1:0] s1_b_hi;

    // Stage 2: valid flag; the result itself lives in out_diff / out_ovf.
    logic            s2_valid;

    logic            s1_load;
    logic            s2_load;

    logic [HALF-1:0] lo_diff;
    logic            lo_borrow;
    logic [HALF-1:0] hi_diff;
    logic            hi_borrow;

    sub_slice #(.N(HALF)) u_slice_lo (
        .a          (in_a[HALF-1:0]),
        .b          (in_b[HALF-1:0]),
        .borrow_in  (1'b0),
        .diff       (lo_diff),
        .borrow_out (lo_borrow)
    );

    sub_slice #(.N(HALF)) u_slice_hi (
        .a          (s1_a_hi),
        .b          (s1_b_hi),
        .borrow_in  (s1_bw_lo),
        .diff       (hi_diff),
        .borrow_out (hi_borrow)
    );

    // Stage 2 takes stage 1 when it is empty or its result is leaving now;
    // the ready path therefore runs combinationally from out_ready.
    always_comb begin
        s2_load  = s1_valid && (!s2_valid || out_ready);
        in_ready = !reset && (!s1_valid || s2_load);
        s1_load  = in_valid && in_ready;
    end

    assign out_valid = s2_valid;

    // Stage 1 occupancy: a new load wins over a drain in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 data: low-half difference and borrow, high operands for the next stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_d_lo  <= '0;
            s1_bw_lo <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
        end else if (s1_load) begin
            s1_d_lo  <= lo_diff;
            s1_bw_lo <= lo_borrow;
            s1_a_hi  <= in_a[WIDTH-1:HALF];
            s1_b_hi  <= in_b[WIDTH-1:HALF];
        end
    end

    // Stage 2 occupancy: refilled on load, emptied when the consumer takes the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Stage 2 data: assemble the full result; held stable while the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_diff <= '0;
            out_ovf  <= 1'b0;
        end else if (s2_load) begin
            out_diff <= {hi_borrow, hi_diff, s1_d_lo};
            out_ovf  <= ovf_sub(s1_a_hi[HALF-1], s1_b_hi[HALF-1], hi_diff[HALF-1]);
        end
    end

endmodule

// File: tb/tb_sub_pipe_2stage.sv
// tb/tb_sub_pipe_2stage.sv - self-checking bench for sub_pipe_2stage
module tb_sub_pipe_2stage;
    import sub_pipe_pkg::*;

    localparam int W    = SUB_WIDTH_DEFAULT;
    localparam int NOPS = 10000;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_diff;
    logic         out_ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   diff;
        logic         ovf;
    } vec_t;

    vec_t        vecs[8];
    sub_result_t sb[$];

    always #5 clock = ~clock;

    sub_pipe_2stage #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Reference: borrow is an unsigned compare, overflow is a signed result out of range.
    function automatic sub_result_t ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        sub_result_t r;
        longint sa, sb_, sd, lim;
        sa       = longint'($signed(a));
        sb_      = longint'($signed(b));
        sd       = sa - sb_;
        lim      = longint'(1) <<< (W - 1);
        r.borrow = (a < b);
        r.diff   = a - b;
        r.ovf    = (sd >= lim) || (sd < -lim);
        return r;
    endfunction

    initial begin
        logic        acc, fire, hold, hold_diff_ovf_valid;
        logic [W+1:0] hold_val;
        sub_result_t exp;
        int          sent, got, idle, n_out, budget;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 33'h0_0000_0002, 1'b0};
        vecs[1] = '{32'h0001_0000, 32'h0000_0001, 33'h0_0000_FFFF, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 33'h1_FFFF_FFFF, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 33'h0_7FFF_FFFF, 1'b1};
        vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 33'h1_8000_0000, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 33'h0_0000_0001, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h8000_0000, 33'h1_8000_0000, 1'b1};
        vecs[7] = '{32'h1234_5678, 32'h1234_5678, 33'h0_0000_0000, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        step;
        step;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_diff",  64'(out_diff),  64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        reset = 1'b0;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        step;

        // Directed vectors, one at a time, checking the 2-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_a     = vecs[i].a;
            in_b     = vecs[i].b;
            in_valid = 1'b1;
            #1;
            check("vec_in_ready", 64'(in_ready), 64'd1);
            step;
            in_valid = 1'b0;
            #1;
            check("vec_lat_early", 64'(out_valid), 64'd0);
            step;
            check("vec_lat_valid", 64'(out_valid), 64'd1);
            check("vec_diff",      64'(out_diff),  64'(vecs[i].diff));
            check("vec_ovf",       64'(out_ovf),   64'(vecs[i].ovf));
            step;
        end
        step;

        // Backpressure: fill with out_ready low, then release.
        out_ready = 1'b0;
        sent      = 0;
        in_valid  = 1'b1;
        in_a      = W'(100);
        in_b      = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), (c < 2) ? 64'd1 : 64'd0);
            if (c >= 2) begin
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_diff",  64'(out_diff),  64'd100);
            end
            acc = in_valid && in_ready;
            step;
            if (acc) begin
                sent++;
                in_a = W'(sent + 100);
                in_b = W'(sent);
            end
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        n_out  = 0;
        budget = 0;
        while (n_out < 10 && budget < 40) begin
            if (sent >= 10) in_valid = 1'b0;
            #1;
            check("bp_no_gap",  64'(out_valid), 64'd1);
            check("bp_out_val", 64'(out_diff),  64'd100);
            acc = in_valid && in_ready;
            if (out_valid) n_out++;
            budget++;
            step;
            if (acc) begin
                sent++;
                in_a = W'(sent + 100);
                in_b = W'(sent);
            end
        end
        check("bp_count", 64'(n_out), 64'd10);
        in_valid = 1'b0;
        step;

        // Random traffic against the scoreboard.
        sent = 0;
        got  = 0;
        idle = 0;
        hold = 1'b0;
        hold_val = '0;
        while (got < NOPS && idle < 200) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < NOPS && $urandom_range(0, 3) != 0) begin
                in_a = $urandom;
                in_b = $urandom;
                case ($urandom_range(0, 7))
                    0: in_b = in_a;
                    1: in_a = 32'h8000_0000 ^ W'($urandom_range(0, 3));
                    2: in_b = 32'h8000_0000 ^ W'($urandom_range(0, 3));
                    3: in_a = W'($urandom_range(0, 3)) << (W / 2);
                    default: ;
                endcase
                in_valid = 1'b1;
            end
            #1;
            if (hold) begin
                hold_diff_ovf_valid = out_valid;
                check("rand_hold_valid", 64'(hold_diff_ovf_valid), 64'd1);
                check("rand_hold_data", 64'({out_ovf, out_diff}), 64'(hold_val));
            end
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            hold = out_valid && !out_ready;
            hold_val = {1'b0, out_ovf, out_diff};
            if (fire) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_spurious: got 0x%0h expected no output", out_diff);
                end else begin
                    exp = sb.pop_front();
                    check("rand_result", 64'({out_ovf, out_diff}),
                          64'({exp.ovf, exp.borrow, exp.diff}));
                end
                got++;
            end
            if (acc) begin
                sb.push_back(ref_sub(in_a, in_b));
                sent++;
            end
            idle = (acc || fire) ? 0 : idle + 1;
            step;
            if (acc) in_valid = 1'b0;
        end
        check("rand_count", 64'(got), 64'(NOPS));
        check("rand_leftover", 64'(sb.size()), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        step;

        // Mid-stream reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h0000_0011;
        in_b      = 32'h0000_0001;
        step;
        step;
        check("mr_full_valid", 64'(out_valid), 64'd1);
        check("mr_full_ready", 64'(in_ready),  64'd0);
        reset = 1'b1;
        #1;
        check("mr_rst_ready", 64'(in_ready), 64'd0);
        step;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_diff",  64'(out_diff),  64'd0);
        check("mr_out_ovf",   64'(out_ovf),   64'd0);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mr_release_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            step;
            check("mr_no_stale", 64'(out_valid), 64'd0);
        end
        in_a     = W'(9);
        in_b     = W'(4);
        in_valid = 1'b1;
        #1;
        check("mr_post_accept", 64'(in_ready), 64'd1);
        step;
        in_valid = 1'b0;
        step;
        check("mr_post_valid", 64'(out_valid), 64'd1);
        check("mr_post_diff",  64'(out_diff),  64'd5);
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
